// File: rtl/seg_display_ctrl.sv
// Four-digit seven-segment sequencer: round-robin between gen/live counts, double-dabble BCD, registered active-low segments.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (seg4..seg2).
module seg_display_ctrl #(
    parameter int unsigned HOLD_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] gen_count,
    input  logic        gen_valid,
    input  logic [11:0] live_count,
    input  logic        live_valid,
    input  logic        freeze,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic        src_sel,
    output logic        busy
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT, S_HOLD} state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              shown_q, shown_d;
    logic [11:0]       val_q, val_d;
    logic [11:0]       sh_q, sh_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [3:0]        bit_q, bit_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [3:0][6:0]   seg_q, seg_d;

    logic [11:0]       cur_val;
    logic              cur_vld, oth_vld;
    logic [15:0]       bcd_adj;
    logic [27:0]       shifted;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    always_comb begin
        cur_val = sel_q ? live_count : gen_count;
        cur_vld = sel_q ? live_valid : gen_valid;
        oth_vld = sel_q ? gen_valid  : live_valid;
        for (int i = 0; i < 4; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
        shifted = {bcd_adj, sh_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        shown_d = shown_q;
        val_d   = val_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        bit_d   = bit_q;
        hold_d  = hold_q;
        seg_d   = seg_q;
        case (state_q)
            S_IDLE: begin
                // With both pending, alternate; before anything has been shown, gen goes first.
                if (gen_valid && live_valid) begin
                    sel_d   = shown_q ? ~sel_q : 1'b0;
                    shown_d = 1'b1;
                    state_d = S_LOAD;
                end else if (gen_valid || live_valid) begin
                    sel_d   = live_valid;
                    shown_d = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                val_d   = sel_q ? live_count : gen_count;
                sh_d    = sel_q ? live_count : gen_count;
                bcd_d   = '0;
                bit_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                {bcd_d, sh_d} = shifted;
                bit_d         = bit_q + 4'd1;
                if (bit_q == 4'd11) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                seg_d[3] = seg7(bcd_q[15:12]);
                seg_d[2] = seg7(bcd_q[11:8]);
                seg_d[1] = seg7(bcd_q[7:4]);
                seg_d[0] = seg7(bcd_q[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
                if (bcd_q[15:12] == 4'd0) seg_d[3] = BLANK;
                if (bcd_q[15:8]  == 8'd0) seg_d[2] = BLANK;
                if (bcd_q[15:4]  == 12'd0) seg_d[1] = BLANK;
`else
`endif
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!cur_vld) begin
                    hold_d = '0;
                    if (oth_vld) begin
                        sel_d   = ~sel_q;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cur_val != val_q) begin
                    // Refresh on the same source; hold time already spent is kept.
                    state_d = S_LOAD;
                end else if (hold_q == HOLD_LAST) begin
                    if (!freeze) begin
                        hold_d  = '0;
                        sel_d   = oth_vld ? ~sel_q : sel_q;
                        state_d = S_LOAD;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            shown_q <= 1'b0;
            val_q   <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            bit_q   <= '0;
            hold_q  <= '0;
            seg_q   <= {4{BLANK}};
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            shown_q <= shown_d;
            val_q   <= val_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            bit_q   <= bit_d;
            hold_q  <= hold_d;
            seg_q   <= seg_d;
        end
    end

    assign busy    = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_COMMIT);
    assign src_sel = sel_q;
    assign seg1    = seg_q[0];
    assign seg2    = seg_q[1];
    assign seg3    = seg_q[2];
    assign seg4    = seg_q[3];

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed + randomized bench for seg_display_ctrl; expected segments come from decimal arithmetic on the value.
module tb_seg_display_ctrl;

    localparam logic [27:0] BLANK4 = 28'hFFFFFFF;
    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] gen_count, live_count;
    logic        gen_valid, live_valid, freeze;
    logic [6:0]  seg1, seg2, seg3, seg4;
    logic        src_sel, busy;
    logic [27:0] segs;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [27:0] cur_segs;
    logic        last_src;
    int          gv, lv, v;

    seg_display_ctrl #(.HOLD_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .gen_count(gen_count), .gen_valid(gen_valid),
        .live_count(live_count), .live_valid(live_valid),
        .freeze(freeze),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .src_sel(src_sel), .busy(busy)
    );

    always #5 clk = ~clk;
    assign segs = {seg4, seg3, seg2, seg1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] exp_segs(input int val);
        logic [6:0] s [4];
        s[0] = PAT[val % 10];
        s[1] = PAT[(val / 10) % 10];
        s[2] = PAT[(val / 100) % 10];
        s[3] = PAT[(val / 1000) % 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (val < 1000) s[3] = 7'h7f;
        if (val < 100)  s[2] = 7'h7f;
        if (val < 10)   s[1] = 7'h7f;
`endif
        return {s[3], s[2], s[1], s[0]};
    endfunction

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at the sample just after the edge entering LOAD.
    task automatic conv_expect(input string tag, input int val, input logic src);
        for (int i = 0; i < 14; i++) begin
            chk({tag, "/busy"}, 28'(busy), 28'(1));
            chk({tag, "/src"}, 28'(src_sel), 28'(src));
            chk({tag, "/segs_hold"}, segs, cur_segs);
            tick();
        end
        chk({tag, "/busy_done"}, 28'(busy), 28'(0));
        chk({tag, "/segs"}, segs, exp_segs(val));
        chk({tag, "/src_done"}, 28'(src_sel), 28'(src));
        cur_segs = exp_segs(val);
        last_src = src;
    endtask

    task automatic hold_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "/hold_busy"}, 28'(busy), 28'(0));
            chk({tag, "/hold_segs"}, segs, cur_segs);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; gen_count = '0; live_count = '0;
        gen_valid = 1'b0; live_valid = 1'b0; freeze = 1'b0;
        cur_segs = BLANK4; last_src = 1'b0;
        tick(); tick();
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("reset/segs", segs, BLANK4);
            chk("reset/busy", 28'(busy), 28'(0));
            chk("reset/src", 28'(src_sel), 28'(0));
        end

        // First conversion from IDLE
        gv = 1234; gen_count = 12'(gv); gen_valid = 1'b1;
        tick();
        conv_expect("gen1234", gv, 1'b0);

        // Refreshes on the same source with boundary and random values
        gv = 0; gen_count = 12'(gv);
        tick();
        conv_expect("gen0", gv, 1'b0);
        for (int k = 0; k < 6; k++) begin
            v = int'($urandom_range(10, 4095));
            if (v == gv) v = (v == 4095) ? 10 : v + 1;
            gv = v; gen_count = 12'(gv);
            tick();
            conv_expect("gen_rand", gv, 1'b0);
        end

        // Refresh keeps the hold count: expiry comes 2 cycles after re-entry instead of 4
        gv = 5; gen_count = 12'(gv);
        tick();
        conv_expect("gen5", gv, 1'b0);
        hold_cycles("pre6", 2);
        gv = 6; gen_count = 12'(gv);
        tick();
        conv_expect("gen6", gv, 1'b0);
        chk("hold_keep/busy0", 28'(busy), 28'(0));
        tick();
        chk("hold_keep/busy0b", 28'(busy), 28'(0));
        tick();
        chk("hold_keep/reload", 28'(busy), 28'(1));
        conv_expect("gen6_reload", gv, 1'b0);

        // Alternation between both sources, 18-cycle period
        gv = 4095; lv = 10;
        gen_count = 12'(gv); live_count = 12'(lv); live_valid = 1'b1;
        tick();
        conv_expect("alt_gen4095", gv, 1'b0);
        for (int k = 0; k < 4; k++) begin
            hold_cycles("alt", 4);
            if (last_src) conv_expect("alt_gen", gv, 1'b0);
            else          conv_expect("alt_live", lv, 1'b1);
        end

        // Freeze pins the current source past expiry
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("freeze/busy", 28'(busy), 28'(0));
            chk("freeze/src", 28'(src_sel), 28'(last_src));
            chk("freeze/segs", segs, cur_segs);
        end
        freeze = 1'b0;
        tick();
        if (last_src) conv_expect("unfreeze_gen", gv, 1'b0);
        else          conv_expect("unfreeze_live", lv, 1'b1);

        // Drop both to IDLE, then both valid again: the other source is picked
        gen_valid = 1'b0; live_valid = 1'b0;
        hold_cycles("idle", 3);
        gv = int'($urandom_range(1000, 4095)); lv = int'($urandom_range(0, 4095));
        gen_count = 12'(gv); live_count = 12'(lv);
        gen_valid = 1'b1; live_valid = 1'b1;
        tick();
        if (last_src) conv_expect("idle_pick_gen", gv, 1'b0);
        else          conv_expect("idle_pick_live", lv, 1'b1);

        // Reset during the 6th SHIFT cycle of converting 999
        gen_count = 12'd999; live_valid = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("rst_mid/busy", 28'(busy), 28'(1));
            tick();
        end
        rst = 1'b1;
        tick();
        chk("rst_mid/segs", segs, BLANK4);
        chk("rst_mid/busy0", 28'(busy), 28'(0));
        chk("rst_mid/src", 28'(src_sel), 28'(0));
        cur_segs = BLANK4;
        rst = 1'b0;
        tick();
        conv_expect("gen999", 999, 1'b0);

        // Selected source drops while the other is valid: switch immediately
        live_count = 12'd7; live_valid = 1'b1; gen_valid = 1'b0;
        tick();
        conv_expect("live7", 7, 1'b1);

        // Reset while showing live; both valid afterwards -> gen first
        gv = int'($urandom_range(0, 4095));
        gen_count = 12'(gv); gen_valid = 1'b1; rst = 1'b1;
        tick();
        chk("rst_hold/segs", segs, BLANK4);
        chk("rst_hold/src", 28'(src_sel), 28'(0));
        cur_segs = BLANK4;
        rst = 1'b0;
        tick();
        conv_expect("post_rst_gen", gv, 1'b0);

        gen_valid = 1'b0; live_valid = 1'b0;
        hold_cycles("final_idle", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
